// File: rtl/robot_motion_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : robot_motion_sequencer_if
// Description : Request and status bundle of the robot motion sequencer.
//               master : request source (line-follower FSM side) that drives
//                        en/a/r/clear and observes motor drives and status.
//               slave  : the sequencer, which consumes requests and drives
//                        the motor and status outputs.
//   en, a, r, clear          : enable, advance request, rotate request,
//                              lock-out release
//   ml_fwd, mr_fwd, mr_rev   : motor drives
//   busy, halted, state      : move in progress, lock-out, current state
//   rot_cnt, move_cnt        : consecutive rotates, completed moves
// Revision    : 1.0 - initial release
// ============================================================================
interface robot_motion_sequencer_if;
  logic       en;
  logic       a;
  logic       r;
  logic       clear;
  logic       ml_fwd;
  logic       mr_fwd;
  logic       mr_rev;
  logic       busy;
  logic       halted;
  logic [1:0] state;
  logic [2:0] rot_cnt;
  logic [7:0] move_cnt;

  modport master (
    output en, a, r, clear,
    input  ml_fwd, mr_fwd, mr_rev, busy, halted, state, rot_cnt, move_cnt
  );

  modport slave (
    input  en, a, r, clear,
    output ml_fwd, mr_fwd, mr_rev, busy, halted, state, rot_cnt, move_cnt
  );
endinterface
`default_nettype wire

// File: rtl/robot_motion_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : robot_motion_sequencer
// Description : Sequences timed advance / rotate moves for a two-motor robot.
//               A move runs for a fixed number of cycles and cannot be
//               preempted; after MAX_ROT consecutive rotations the block
//               locks out in HALT until clear is asserted.
// Ports       : clk   - clock, rising edge active
//               reset - asynchronous active-low reset
//               bus   - request/status bundle (slave side)
// Revision    : 1.0 - initial release
// ============================================================================
module robot_motion_sequencer #(
  parameter int ADV_CYCLES = 4,
  parameter int ROT_CYCLES = 2,
  parameter int MAX_ROT    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  robot_motion_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADV  = 2'd1,
    ST_ROT  = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  localparam logic [3:0] ADV_LOAD  = 4'(ADV_CYCLES - 1);
  localparam logic [3:0] ROT_LOAD  = 4'(ROT_CYCLES - 1);
  localparam logic [2:0] MAX_ROT_C = 3'(MAX_ROT);

  state_t     state_q, state_d;
  logic [3:0] timer_q, timer_d;
  logic [2:0] rot_cnt_q, rot_cnt_d;
  logic [7:0] move_cnt_q, move_cnt_d;
  logic       ml_fwd_q, mr_fwd_q, mr_rev_q, busy_q, halted_q;
  logic       ml_fwd_d, mr_fwd_d, mr_rev_d, busy_d, halted_d;
  logic       decide;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    rot_cnt_d  = rot_cnt_q;
    move_cnt_d = move_cnt_q;
    decide     = 1'b0;

    case (state_q)
      ST_IDLE: decide = 1'b1;
      ST_ADV, ST_ROT: begin
        if (timer_q != 4'd0) begin
          timer_d = timer_q - 4'd1;
        end else begin
          move_cnt_d = move_cnt_q + 8'd1;
          // Lock-out wins over any pending request on the final rotate.
          if (state_q == ST_ROT && rot_cnt_q == MAX_ROT_C) begin
            state_d = ST_HALT;
          end else begin
            decide = 1'b1;
          end
        end
      end
      ST_HALT: begin
        if (bus.clear) begin
          state_d   = ST_IDLE;
          rot_cnt_d = 3'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Shared decision point: rotate has priority over advance.
    if (decide) begin
      if (bus.en && bus.r) begin
        state_d   = ST_ROT;
        timer_d   = ROT_LOAD;
        rot_cnt_d = rot_cnt_q + 3'd1;
      end else if (bus.en && bus.a) begin
        state_d   = ST_ADV;
        timer_d   = ADV_LOAD;
        rot_cnt_d = 3'd0;
      end else begin
        state_d   = ST_IDLE;
      end
    end

    // Outputs are registered from the next state so they line up with state_q.
    ml_fwd_d = (state_d == ST_ADV) || (state_d == ST_ROT);
    mr_fwd_d = (state_d == ST_ADV);
    mr_rev_d = (state_d == ST_ROT);
    busy_d   = (state_d == ST_ADV) || (state_d == ST_ROT);
    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= 4'd0;
      rot_cnt_q  <= 3'd0;
      move_cnt_q <= 8'd0;
      ml_fwd_q   <= 1'b0;
      mr_fwd_q   <= 1'b0;
      mr_rev_q   <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      rot_cnt_q  <= rot_cnt_d;
      move_cnt_q <= move_cnt_d;
      ml_fwd_q   <= ml_fwd_d;
      mr_fwd_q   <= mr_fwd_d;
      mr_rev_q   <= mr_rev_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.state    = state_q;
  assign bus.rot_cnt  = rot_cnt_q;
  assign bus.move_cnt = move_cnt_q;
  assign bus.ml_fwd   = ml_fwd_q;
  assign bus.mr_fwd   = mr_fwd_q;
  assign bus.mr_rev   = mr_rev_q;
  assign bus.busy     = busy_q;
  assign bus.halted   = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_robot_motion_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_robot_motion_sequencer
// Description : Directed self-checking bench for robot_motion_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_robot_motion_sequencer;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic overlap_seen;

  robot_motion_sequencer_if bus ();

  robot_motion_sequencer #(
    .ADV_CYCLES (4),
    .ROT_CYCLES (2),
    .MAX_ROT    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial overlap_seen = 1'b0;
  always @(negedge clk) begin
    if (bus.mr_fwd === 1'b1 && bus.mr_rev === 1'b1) overlap_seen <= 1'b1;
  end

  // Expected observation vector from state, rot_cnt and move_cnt.
  function automatic logic [17:0] exp_vec(input logic [1:0] st,
                                          input logic [2:0] rc,
                                          input logic [7:0] mc);
    logic ml, mf, mrv, bsy, hlt;
    ml  = (st == 2'd1) || (st == 2'd2);
    mf  = (st == 2'd1);
    mrv = (st == 2'd2);
    bsy = (st == 2'd1) || (st == 2'd2);
    hlt = (st == 2'd3);
    return {st, ml, mf, mrv, bsy, hlt, rc, mc};
  endfunction

  task automatic chk(input string tag, input logic [1:0] st,
                     input logic [2:0] rc, input logic [7:0] mc);
    logic [17:0] obs;
    logic [17:0] exp;
    obs = {bus.state, bus.ml_fwd, bus.mr_fwd, bus.mr_rev, bus.busy,
           bus.halted, bus.rot_cnt, bus.move_cnt};
    exp = exp_vec(st, rc, mc);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    reset  = 1'b1;
    bus.en = 1'b0; bus.a = 1'b0; bus.r = 1'b0; bus.clear = 1'b0;

    // Asynchronous reset before any clock edge.
    #2 reset = 1'b0;
    #1 chk("reset_async", 2'd0, 3'd0, 8'd0);
    tick;
    tick;
    reset = 1'b1;
    chk("reset_state", 2'd0, 3'd0, 8'd0);

    // en=0 blocks requests.
    bus.a = 1'b1;
    tick;
    chk("en_low_idle", 2'd0, 3'd0, 8'd0);

    // Two back-to-back advances, no bubble.
    bus.en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick;
      chk("adv_held", 2'd1, 3'd0, (i >= 5) ? 8'd1 : 8'd0);
    end
    bus.a = 1'b0;
    tick;
    chk("adv_done", 2'd0, 3'd0, 8'd2);

    // Rotate priority over advance, single rotate move.
    bus.a = 1'b1; bus.r = 1'b1;
    tick;
    chk("rot_prio", 2'd2, 3'd1, 8'd2);
    bus.a = 1'b0; bus.r = 1'b0;
    tick;
    chk("rot_cyc2", 2'd2, 3'd1, 8'd2);
    tick;
    chk("rot_done", 2'd0, 3'd1, 8'd3);

    // clear outside HALT has no effect.
    bus.clear = 1'b1;
    tick;
    chk("clear_idle", 2'd0, 3'd1, 8'd3);
    bus.clear = 1'b0;

    // Fresh start, rotate lock-out.
    reset = 1'b0;
    tick;
    reset = 1'b1;
    chk("reset_mid", 2'd0, 3'd0, 8'd0);
    bus.r = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick;
      chk("rot_run", 2'd2, 3'((k + 1) / 2), 8'((k - 1) / 2));
    end
    tick;
    chk("halt_enter", 2'd3, 3'd4, 8'd4);
    tick;
    chk("halt_hold", 2'd3, 3'd4, 8'd4);
    bus.r = 1'b0; bus.clear = 1'b1;
    tick;
    chk("halt_clear", 2'd0, 3'd0, 8'd4);
    bus.clear = 1'b0;

    // Advance not preempted by input changes.
    bus.a = 1'b1;
    tick;
    chk("np_start", 2'd1, 3'd0, 8'd4);
    bus.a = 1'b0; bus.en = 1'b0; bus.r = 1'b1; bus.clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("np_hold", 2'd1, 3'd0, 8'd4);
    end
    tick;
    chk("np_done", 2'd0, 3'd0, 8'd5);
    bus.clear = 1'b0;

    // Async reset during second cycle of a rotate.
    bus.en = 1'b1;
    tick;
    chk("ar_rot1", 2'd2, 3'd1, 8'd5);
    tick;
    chk("ar_rot2", 2'd2, 3'd1, 8'd5);
    #2 reset = 1'b0;
    #1 chk("ar_async", 2'd0, 3'd0, 8'd0);
    bus.r = 1'b0; bus.a = 1'b1;
    tick;
    chk("ar_held", 2'd0, 3'd0, 8'd0);
    reset = 1'b1;
    tick;
    chk("ar_release", 2'd1, 3'd0, 8'd0);

    // 256 advance moves wrap move_cnt.
    repeat (1020) tick;
    chk("wrap_255", 2'd1, 3'd0, 8'd255);
    repeat (4) tick;
    chk("wrap_0", 2'd1, 3'd0, 8'd0);
    bus.a = 1'b0;
    repeat (4) tick;
    chk("wrap_idle", 2'd0, 3'd0, 8'd1);

    // Right motor never driven both ways.
    total++;
    assert (overlap_seen === 1'b0)
      else begin
        bad++;
        $error("FAIL mr_overlap observed=%b expected=0", overlap_seen);
      end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
